// File: rtl/cdb_broadcaster_if.sv
// Result-offer and broadcast bundle between the functional units, the CDB
// transmit block and its consumers (ROB, RS, map table).
interface cdb_broadcaster_if #(
  parameter int ROB_SIZE = 32,
  parameter int XLEN     = 32,
  parameter int NUM_FU   = 4
);
  localparam int TW = $clog2(ROB_SIZE);

  logic [NUM_FU-1:0]      fu_valid;
  logic [NUM_FU*TW-1:0]   fu_tag;
  logic [NUM_FU*XLEN-1:0] fu_value;
  logic [NUM_FU-1:0]      fu_take_branch;
  logic [NUM_FU*XLEN-1:0] fu_npc;
  logic [NUM_FU-1:0]      fu_ready;

  logic                   cdb_valid;
  logic [TW-1:0]          cdb_tag;
  logic [XLEN-1:0]        cdb_value;
  logic                   cdb_take_branch;
  logic [XLEN-1:0]        cdb_npc;

  // master: the FU side that offers results and observes the broadcast
  modport master (
    output fu_valid, fu_tag, fu_value, fu_take_branch, fu_npc,
    input  fu_ready,
    input  cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc
  );

  // slave: the broadcaster itself
  modport slave (
    input  fu_valid, fu_tag, fu_value, fu_take_branch, fu_npc,
    output fu_ready,
    output cdb_valid, cdb_tag, cdb_value, cdb_take_branch, cdb_npc
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// Common data bus transmit end: per-FU result FIFOs, a round-robin arbiter
// over the FIFO heads, and a registered one-result-per-cycle broadcast.
module cdb_broadcaster #(
  parameter int ROB_SIZE  = 32,
  parameter int XLEN      = 32,
  parameter int NUM_FU    = 4,
  parameter int BUF_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash_signal,
  cdb_broadcaster_if.slave bus
);
  localparam int TW = $clog2(ROB_SIZE);
  localparam int FW = $clog2(NUM_FU);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);

  logic [TW-1:0]     buf_tag    [NUM_FU][BUF_DEPTH];
  logic [XLEN-1:0]   buf_value  [NUM_FU][BUF_DEPTH];
  logic              buf_branch [NUM_FU][BUF_DEPTH];
  logic [XLEN-1:0]   buf_npc    [NUM_FU][BUF_DEPTH];

  logic [PW-1:0]     wr_ptr [NUM_FU];
  logic [PW-1:0]     rd_ptr [NUM_FU];
  logic [CW-1:0]     count  [NUM_FU];

  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] not_empty;
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;

  logic              grant_valid;
  logic [FW-1:0]     grant_idx;
  logic [FW-1:0]     rr_ptr;

  logic [TW-1:0]     head_tag;
  logic [XLEN-1:0]   head_value;
  logic              head_branch;
  logic [XLEN-1:0]   head_npc;

  logic              cdb_valid_q;
  logic [TW-1:0]     cdb_tag_q;
  logic [XLEN-1:0]   cdb_value_q;
  logic              cdb_branch_q;
  logic [XLEN-1:0]   cdb_npc_q;

  // flush_now covers both reset and squash: every in-flight result is dropped
  logic              flush_now;
  assign flush_now = !reset || squash_signal;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // ready depends on the registered count only, so a full FIFO stays
  // not-ready even in a cycle where its head is being granted
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign ready[gi]     = (count[gi] < CNT_FULL);
    assign not_empty[gi] = (count[gi] != '0);
    assign push[gi]      = bus.fu_valid[gi] & ready[gi];
    assign pop[gi]       = grant_valid & (grant_idx == FW'(gi));
  end

  always_comb begin
    logic [FW-1:0] scan_idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = rr_ptr + FW'(k);
      if (!grant_valid && not_empty[scan_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    head_tag    = buf_tag[grant_idx][rd_ptr[grant_idx]];
    head_value  = buf_value[grant_idx][rd_ptr[grant_idx]];
    head_branch = buf_branch[grant_idx][rd_ptr[grant_idx]];
    head_npc    = buf_npc[grant_idx][rd_ptr[grant_idx]];
  end

  // storage carries no reset; validity lives entirely in the count
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (!flush_now && push[i]) begin
        buf_tag[i][wr_ptr[i]]    <= bus.fu_tag[i*TW +: TW];
        buf_value[i][wr_ptr[i]]  <= bus.fu_value[i*XLEN +: XLEN];
        buf_branch[i][wr_ptr[i]] <= bus.fu_take_branch[i];
        buf_npc[i][wr_ptr[i]]    <= bus.fu_npc[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (flush_now) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
        if (pop[i])  rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CW'(1);
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CW'(1);
        end
      end
    end
  end

  // NUM_FU is a power of two, so the pointer wraps naturally
  always_ff @(posedge clock) begin
    if (flush_now) begin
      rr_ptr       <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_value_q  <= '0;
      cdb_branch_q <= 1'b0;
      cdb_npc_q    <= '0;
    end else if (grant_valid) begin
      rr_ptr       <= grant_idx + FW'(1);
      cdb_valid_q  <= 1'b1;
      cdb_tag_q    <= head_tag;
      cdb_value_q  <= head_value;
      cdb_branch_q <= head_branch;
      cdb_npc_q    <= head_npc;
    end else begin
      cdb_valid_q  <= 1'b0;
    end
  end

  assign bus.fu_ready        = ready;
  assign bus.cdb_valid       = cdb_valid_q;
  assign bus.cdb_tag         = cdb_tag_q;
  assign bus.cdb_value       = cdb_value_q;
  assign bus.cdb_take_branch = cdb_branch_q;
  assign bus.cdb_npc         = cdb_npc_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, single-result latency, full
// round robin, backpressure, squash and interleaved streams.
module tb_cdb_broadcaster;
  localparam int ROB_SIZE  = 32;
  localparam int XLEN      = 32;
  localparam int NUM_FU    = 4;
  localparam int BUF_DEPTH = 2;
  localparam int TW        = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic squash_signal = 1'b0;

  cdb_broadcaster_if #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .NUM_FU(NUM_FU)) bus ();

  cdb_broadcaster #(
    .ROB_SIZE(ROB_SIZE), .XLEN(XLEN), .NUM_FU(NUM_FU), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .squash_signal(squash_signal),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [TW-1:0]     log_tag   [$];
  logic [XLEN-1:0]   log_value [$];
  logic [XLEN-1:0]   log_npc   [$];
  logic              log_br    [$];
  logic [NUM_FU-1:0] ready_log [$];

  int stim_tag [NUM_FU][16];
  int stim_len [NUM_FU];
  int stim_pos [NUM_FU];
  int acc_edge [NUM_FU][16];

  function automatic logic [XLEN-1:0] val_of(input int fu, input int tag);
    return XLEN'(32'h1000 * (fu + 1) + tag);
  endfunction

  function automatic logic [XLEN-1:0] npc_of(input int tag);
    return XLEN'(32'h400 + tag * 4);
  endfunction

  task automatic clear_inputs();
    bus.fu_valid       = '0;
    bus.fu_tag         = '0;
    bus.fu_value       = '0;
    bus.fu_take_branch = '0;
    bus.fu_npc         = '0;
  endtask

  task automatic clear_log();
    log_tag.delete();
    log_value.delete();
    log_npc.delete();
    log_br.delete();
    ready_log.delete();
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.cdb_valid === 1'b1) begin
      log_tag.push_back(bus.cdb_tag);
      log_value.push_back(bus.cdb_value);
      log_npc.push_back(bus.cdb_npc);
      log_br.push_back(bus.cdb_take_branch);
    end
  endtask

  task automatic offer(input int fu, input int tag);
    bus.fu_valid[fu]              = 1'b1;
    bus.fu_tag[fu*TW +: TW]       = TW'(tag);
    bus.fu_value[fu*XLEN +: XLEN] = val_of(fu, tag);
    bus.fu_npc[fu*XLEN +: XLEN]   = npc_of(tag);
    bus.fu_take_branch[fu]        = tag[0];
  endtask

  task automatic do_squash();
    clear_inputs();
    squash_signal = 1'b1;
    tick();
    squash_signal = 1'b0;
    clear_log();
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NUM_FU; i++) begin
      stim_len[i] = 0;
      stim_pos[i] = 0;
    end
  endtask

  // Present each FU's pending result every cycle; advance only when accepted.
  task automatic run_streams(input int ncyc);
    logic [NUM_FU-1:0] rdy;
    logic [NUM_FU-1:0] offered;
    for (int c = 0; c < ncyc; c++) begin
      clear_inputs();
      for (int i = 0; i < NUM_FU; i++)
        if (stim_pos[i] < stim_len[i]) offer(i, stim_tag[i][stim_pos[i]]);
      offered = bus.fu_valid;
      rdy = bus.fu_ready;
      tick();
      for (int i = 0; i < NUM_FU; i++) begin
        if (offered[i] && rdy[i]) begin
          acc_edge[i][stim_pos[i]] = c;
          stim_pos[i]++;
        end
      end
      ready_log.push_back(bus.fu_ready);
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      bus.fu_valid       = NUM_FU'($urandom);
      bus.fu_tag         = (NUM_FU*TW)'($urandom);
      bus.fu_take_branch = NUM_FU'($urandom);
      for (int i = 0; i < NUM_FU; i++) begin
        bus.fu_value[i*XLEN +: XLEN] = $urandom;
        bus.fu_npc[i*XLEN +: XLEN]   = $urandom;
      end
      squash_signal = 1'($urandom);
      tick();
    end
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_tag !== '0) begin n_bad++; $display("FAIL reset_tag: got %0h want 0", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_value !== '0) begin n_bad++; $display("FAIL reset_value: got %0h want 0", bus.cdb_value); end
    n_cmp++; if (bus.cdb_npc !== '0) begin n_bad++; $display("FAIL reset_npc: got %0h want 0", bus.cdb_npc); end
    n_cmp++; if (bus.cdb_take_branch !== 1'b0) begin n_bad++; $display("FAIL reset_branch: got %0b want 0", bus.cdb_take_branch); end
    n_cmp++; if (bus.fu_ready !== 4'b1111) begin n_bad++; $display("FAIL reset_ready: got %b want 1111", bus.fu_ready); end
    squash_signal = 1'b0;
    clear_inputs();
    reset = 1'b1;
    clear_log();
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (log_tag.size() != 0) begin n_bad++; $display("FAIL reset_no_leak: got %0d broadcasts want 0", log_tag.size()); end
    n_cmp++; if (bus.fu_ready !== 4'b1111) begin n_bad++; $display("FAIL reset_ready_idle: got %b want 1111", bus.fu_ready); end
  endtask

  task automatic test_single();
    clear_inputs();
    bus.fu_valid[2]           = 1'b1;
    bus.fu_tag[2*TW +: TW]    = 5'd5;
    bus.fu_value[2*XLEN +: XLEN] = 32'h1234;
    bus.fu_npc[2*XLEN +: XLEN]   = 32'h40;
    bus.fu_take_branch[2]     = 1'b1;
    tick();
    clear_inputs();
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %0b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.fu_ready !== 4'b1111) begin n_bad++; $display("FAIL single_ready: got %b want 1111", bus.fu_ready); end
    tick();
    n_cmp++; if (bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %0b want 1", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_tag !== 5'd5) begin n_bad++; $display("FAIL single_tag: got %0d want 5", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_value !== 32'h1234) begin n_bad++; $display("FAIL single_value: got %0h want 1234", bus.cdb_value); end
    n_cmp++; if (bus.cdb_npc !== 32'h40) begin n_bad++; $display("FAIL single_npc: got %0h want 40", bus.cdb_npc); end
    n_cmp++; if (bus.cdb_take_branch !== 1'b1) begin n_bad++; $display("FAIL single_branch: got %0b want 1", bus.cdb_take_branch); end
    tick();
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL single_once: got %0b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_tag !== 5'd5) begin n_bad++; $display("FAIL single_hold_tag: got %0d want 5", bus.cdb_tag); end
  endtask

  task automatic test_all_fu();
    do_squash();
    for (int i = 0; i < NUM_FU; i++) offer(i, i + 1);
    tick();
    clear_inputs();
    for (int i = 0; i < NUM_FU; i++) begin
      tick();
      n_cmp++;
      if (bus.cdb_valid !== 1'b1 || bus.cdb_tag !== TW'(i + 1) || bus.cdb_value !== val_of(i, i + 1)) begin
        n_bad++;
        $display("FAIL all_fu_order[%0d]: got valid=%0b tag=%0d value=%0h want valid=1 tag=%0d value=%0h",
                 i, bus.cdb_valid, bus.cdb_tag, bus.cdb_value, i + 1, val_of(i, i + 1));
      end
    end
    // rr_ptr should be back at 0, so FU0 beats FU3
    offer(0, 7);
    offer(3, 8);
    tick();
    clear_inputs();
    tick();
    n_cmp++; if (bus.cdb_tag !== 5'd7 || bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL rr_wrap_first: got tag %0d want 7", bus.cdb_tag); end
    tick();
    n_cmp++; if (bus.cdb_tag !== 5'd8 || bus.cdb_valid !== 1'b1) begin n_bad++; $display("FAIL rr_wrap_second: got tag %0d want 8", bus.cdb_tag); end
    tick();
  endtask

  task automatic test_backpressure();
    int exp_tag [8];
    int exp_fu  [8];
    logic [NUM_FU-1:0] r;
    exp_tag = '{9, 20, 10, 21, 11, 22, 12, 23};
    exp_fu  = '{0, 1, 0, 1, 0, 1, 0, 1};
    do_squash();
    clear_stim();
    stim_tag[0][0] = 9;  stim_tag[0][1] = 10; stim_tag[0][2] = 11; stim_tag[0][3] = 12;
    stim_tag[1][0] = 20; stim_tag[1][1] = 21; stim_tag[1][2] = 22; stim_tag[1][3] = 23;
    stim_len[0] = 4;
    stim_len[1] = 4;
    run_streams(12);
    r = ready_log[1];
    n_cmp++; if (r[0] !== 1'b1) begin n_bad++; $display("FAIL bp_ready_e1: got %0b want 1", r[0]); end
    r = ready_log[2];
    n_cmp++; if (r[0] !== 1'b0) begin n_bad++; $display("FAIL bp_full_e2: got %0b want 0", r[0]); end
    r = ready_log[3];
    n_cmp++; if (r[0] !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_pop: got %0b want 1", r[0]); end
    n_cmp++; if (acc_edge[0][2] != 2) begin n_bad++; $display("FAIL bp_accept_11: got edge %0d want 2", acc_edge[0][2]); end
    n_cmp++; if (acc_edge[0][3] != 4) begin n_bad++; $display("FAIL bp_accept_12: got edge %0d want 4", acc_edge[0][3]); end
    n_cmp++; if (log_tag.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", log_tag.size()); end
    for (int k = 0; k < 8 && k < log_tag.size(); k++) begin
      n_cmp++;
      if (log_tag[k] !== TW'(exp_tag[k]) || log_value[k] !== val_of(exp_fu[k], exp_tag[k])) begin
        n_bad++;
        $display("FAIL bp_seq[%0d]: got tag=%0d value=%0h want tag=%0d value=%0h",
                 k, log_tag[k], log_value[k], exp_tag[k], val_of(exp_fu[k], exp_tag[k]));
      end
    end
  endtask

  task automatic test_squash();
    clear_inputs();
    offer(0, 1);
    offer(1, 2);
    offer(2, 3);
    tick();
    clear_inputs();
    offer(0, 4);
    offer(1, 5);
    offer(2, 6);
    squash_signal = 1'b1;
    tick();
    squash_signal = 1'b0;
    clear_inputs();
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_bad++; $display("FAIL squash_valid: got %0b want 0", bus.cdb_valid); end
    n_cmp++; if (bus.cdb_tag !== '0) begin n_bad++; $display("FAIL squash_tag: got %0d want 0", bus.cdb_tag); end
    n_cmp++; if (bus.cdb_value !== '0) begin n_bad++; $display("FAIL squash_value: got %0h want 0", bus.cdb_value); end
    n_cmp++; if (bus.cdb_npc !== '0) begin n_bad++; $display("FAIL squash_npc: got %0h want 0", bus.cdb_npc); end
    n_cmp++; if (bus.fu_ready !== 4'b1111) begin n_bad++; $display("FAIL squash_ready: got %b want 1111", bus.fu_ready); end
    clear_log();
    for (int c = 0; c < 6; c++) tick();
    n_cmp++; if (log_tag.size() != 0) begin n_bad++; $display("FAIL squash_no_old_tags: got %0d broadcasts want 0", log_tag.size()); end
  endtask

  task automatic test_streams();
    int et;
    int ef;
    do_squash();
    clear_stim();
    for (int k = 0; k < 10; k++) begin
      stim_tag[1][k] = 1 + k;
      stim_tag[3][k] = 17 + k;
    end
    stim_len[1] = 10;
    stim_len[3] = 10;
    run_streams(24);
    n_cmp++; if (stim_pos[1] != 10 || stim_pos[3] != 10) begin n_bad++; $display("FAIL stream_accepted: got %0d/%0d want 10/10", stim_pos[1], stim_pos[3]); end
    n_cmp++; if (log_tag.size() != 20) begin n_bad++; $display("FAIL stream_count: got %0d want 20", log_tag.size()); end
    for (int k = 0; k < 20 && k < log_tag.size(); k++) begin
      ef = (k % 2 == 0) ? 1 : 3;
      et = (k % 2 == 0) ? (k / 2 + 1) : (17 + k / 2);
      n_cmp++;
      if (log_tag[k] !== TW'(et) || log_value[k] !== val_of(ef, et) ||
          log_npc[k] !== npc_of(et) || log_br[k] !== et[0]) begin
        n_bad++;
        $display("FAIL stream_seq[%0d]: got tag=%0d value=%0h npc=%0h br=%0b want tag=%0d value=%0h npc=%0h br=%0b",
                 k, log_tag[k], log_value[k], log_npc[k], log_br[k], et, val_of(ef, et), npc_of(et), et[0]);
      end
    end
  endtask

  initial begin
    clear_inputs();
    clear_log();
    clear_stim();
    test_reset();
    test_single();
    test_all_fu();
    test_backpressure();
    test_squash();
    test_streams();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
